// File: rtl/piso_bit_serializer_if.sv
// Word-in / bit-out bundle between a word source, the serializer and the detector.
// master drives words and the shift enable; slave is the serializer itself.
interface piso_bit_serializer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             shift_en;
  logic             x_out;
  logic             x_valid;
  logic             busy;
  logic [CNT_W-1:0] words_sent;

  modport master (
    output din, din_valid, shift_en,
    input  din_ready, x_out, x_valid, busy, words_sent
  );

  modport slave (
    input  din, din_valid, shift_en,
    output din_ready, x_out, x_valid, busy, words_sent
  );
endinterface

// File: rtl/piso_bit_serializer.sv
// Parallel-in serial-out stage feeding a bit-sequence detector; gapless word chaining,
// shift-enable stall and selectable bit order.
module piso_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input logic                   clk,
  input logic                   reset,
  piso_bit_serializer_if.slave  bus
);

  localparam int unsigned CntBits = $clog2(WIDTH);
  localparam logic [CntBits-1:0] LastIdx = CntBits'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [CntBits-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]   words_q, words_d;

  logic             in_shift;
  logic             last_bit;
  logic             out_bit;
  logic             load;
  logic [WIDTH-1:0] sreg_shifted;

  assign in_shift = (state_q == StShift);
  assign last_bit = (cnt_q == LastIdx);

  // Output end is the MSB or LSB; the vacated end fills with zero.
  assign out_bit      = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.din_valid) load = 1'b1;
      end
      StShift: begin
        if (bus.shift_en) begin
          if (!last_bit) begin
            sreg_d = sreg_shifted;
            cnt_d  = cnt_q + CntBits'(1);
          end else begin
            words_d = words_q + CNT_W'(1);
            if (bus.din_valid) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
              sreg_d  = '0;
              cnt_d   = '0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d = StShift;
      sreg_d  = bus.din;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
    end
  end

  // din_ready in SHIFT is the combinational "last bit leaving this edge" term.
  assign bus.din_ready  = !in_shift || (last_bit && bus.shift_en);
  assign bus.x_out      = in_shift && out_bit;
  assign bus.x_valid    = in_shift && bus.shift_en;
  assign bus.busy       = in_shift;
  assign bus.words_sent = words_q;

endmodule
